preg_free_list: RTL
===================

PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL take parameter PREG_SIZE, default 128: number of physical registers.
REQ-002 SHALL take parameter ARCH_REGS, default 32: number of architectural registers; pregs 0..ARCH_REGS-1 are mapped at reset.
REQ-003 SHALL take parameter ALLOC_WIDTH, default 4: rename slots per cycle.
REQ-004 SHALL take parameter FREE_WIDTH, default 4: commit/walk slots per cycle.
REQ-005 SHALL use FL_DEPTH = PREG_SIZE-ARCH_REGS, PW = log2(PREG_SIZE), PTR = log2(FL_DEPTH)+1 (includes wrap bit).
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 alloc_req  in  ALLOC_WIDTH  per-slot request for a new destination preg.
REQ-009 alloc_fire  in  1  rename group accepted this cycle.
REQ-010 alloc_ready  out  1  at least ALLOC_WIDTH free entries available.
REQ-011 alloc_prd  out  ALLOC_WIDTH x PW  preg assigned to each requesting slot.
REQ-012 redirect  in  1  backend redirect; suppresses allocation.
REQ-013 free_en  in  FREE_WIDTH  commit slot releases its old preg.
REQ-014 free_prd  in  FREE_WIDTH x PW  old preg being released.
REQ-015 walk  in  1  rollback walk active.
REQ-016 walk_en  in  FREE_WIDTH  walked slot had allocated a preg.
REQ-017 free_cnt  out  PTR  current number of free entries.

Function
REQ-018 SHALL hold a FL_DEPTH-entry ring of PW-bit preg indices with head (read) and tail (write) pointers of PTR bits; index = low bits, MSB = wrap.
REQ-019 free_cnt SHALL equal tail-head (PTR-bit modular); empty when equal, full when indices equal and wrap bits differ.
REQ-020 alloc_prd[i] SHALL be ring[(head + popcount(alloc_req[i-1:0])) mod FL_DEPTH], combinationally from current state; undefined when alloc_req[i]=0.
REQ-021 alloc_ready SHALL be 1 iff free_cnt >= ALLOC_WIDTH, independent of alloc_req.
REQ-022 Allocation SHALL occur iff alloc_fire & alloc_ready & ~redirect & ~walk; head then advances by popcount(alloc_req) on the next edge.
REQ-023 alloc_fire while alloc_ready=0, redirect=1 or walk=1 SHALL leave head unchanged.
REQ-024 Free: for each free_en[j], free_prd[j] SHALL be written at ring[(tail + popcount(free_en[j-1:0])) mod FL_DEPTH]; tail advances by popcount(free_en); 1-cycle latency to visibility in alloc_prd.
REQ-025 Walk: when walk=1, head SHALL move back by popcount(walk_en) (modular); entries are not rewritten, previously allocated values in [head-k, head) are reused.
REQ-026 Allocation, free and walk SHALL all update in the same cycle when enabled; free and walk never conflict because freed slots lie outside the walked range.
REQ-027 Pointer arithmetic SHALL wrap modulo FL_DEPTH on index and toggle wrap bit on crossing; FL_DEPTH need not be a power of two.
REQ-028 Free when full, or walk exceeding allocated count, is illegal; SHALL be flagged by simulation assertion, no RTL recovery.
REQ-029 No output other than free_cnt/alloc_ready/alloc_prd; all outputs derived from registered state only (no input-to-output path except alloc_req→alloc_prd).

Reset
REQ-030 On rst, ring[i] SHALL be ARCH_REGS+i for i in 0..FL_DEPTH-1.
REQ-031 On rst, head SHALL be 0 and tail SHALL be FL_DEPTH index-wrapped (index 0, wrap 1); free_cnt = FL_DEPTH, alloc_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight allocations and restore REQ-030/031 immediately.

Verification
REQ-033 After reset, alloc_req=1111, alloc_fire=1 one cycle -> alloc_prd = 32,33,34,35; next cycle free_cnt=92, alloc_prd[0]=36.
REQ-034 alloc_req=1010, alloc_fire=1 -> alloc_prd[1]=32, alloc_prd[3]=33; head +2, free_cnt=94.
REQ-035 Allocate 24 cycles x4 -> free_cnt=0, alloc_ready=0; alloc_fire ignored; then free_en=0011 prd 5,9 -> free_cnt=2; four more such frees -> alloc_ready=1, next alloc_prd[0]=5.
REQ-036 Allocate 8 (32..39), walk=1 walk_en=1111 twice -> free_cnt=96, head=0; next alloc returns 32,33,34,35 again.
REQ-037 Same cycle: alloc 4, free 2, redirect=0 -> free_cnt changes by -2; with redirect=1 -> +2 only.
REQ-038 Wrap: run ≥3 full ring cycles of alloc/free with FL_DEPTH=96 -> every freed preg reallocated exactly once, free_cnt never exceeds 96.

Source files
------------

// File: rtl/preg_free_list.sv
// Physical-register free list: a ring of free preg indices consumed at rename,
// refilled at commit, and rewound by a rollback walk.
module preg_free_list #(
    parameter  int PREG_SIZE   = 128,
    parameter  int ARCH_REGS   = 32,
    parameter  int ALLOC_WIDTH = 4,
    parameter  int FREE_WIDTH  = 4,
    localparam int FL_DEPTH    = PREG_SIZE - ARCH_REGS,
    localparam int PW          = $clog2(PREG_SIZE),
    localparam int PTR         = $clog2(FL_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALLOC_WIDTH-1:0]    alloc_req,
    input  logic                      alloc_fire,
    output logic                      alloc_ready,
    output logic [ALLOC_WIDTH*PW-1:0] alloc_prd,
    input  logic                      redirect,
    input  logic [FREE_WIDTH-1:0]     free_en,
    input  logic [FREE_WIDTH*PW-1:0]  free_prd,
    input  logic                      walk,
    input  logic [FREE_WIDTH-1:0]     walk_en,
    output logic [PTR-1:0]            free_cnt
);

    localparam int IW = PTR - 1;

    logic [PW-1:0]  ring [FL_DEPTH];
    logic [PTR-1:0] head;
    logic [PTR-1:0] tail;
    logic           do_alloc;
    int             alloc_n;
    int             free_n;
    int             walk_n;

    function automatic int ones_below(logic [31:0] v, int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c;
    endfunction

    // Index arithmetic is done in int so FL_DEPTH need not be a power of two.
    function automatic logic [IW-1:0] idx_add(logic [IW-1:0] idx, int n);
        int s;
        s = int'(idx) + n;
        if (s >= FL_DEPTH) s -= FL_DEPTH;
        return IW'(s);
    endfunction

    function automatic logic [PTR-1:0] ptr_fwd(logic [PTR-1:0] p, int n);
        int   s;
        logic w;
        s = int'(p[IW-1:0]) + n;
        w = p[PTR-1];
        if (s >= FL_DEPTH) begin
            s -= FL_DEPTH;
            w  = ~w;
        end
        return {w, IW'(s)};
    endfunction

    function automatic logic [PTR-1:0] ptr_back(logic [PTR-1:0] p, int n);
        int   s;
        logic w;
        s = int'(p[IW-1:0]) - n;
        w = p[PTR-1];
        if (s < 0) begin
            s += FL_DEPTH;
            w  = ~w;
        end
        return {w, IW'(s)};
    endfunction

    // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        int cnt;
        if (head[PTR-1] == tail[PTR-1]) cnt = int'(tail[IW-1:0]) - int'(head[IW-1:0]);
        else                            cnt = FL_DEPTH + int'(tail[IW-1:0]) - int'(head[IW-1:0]);
        free_cnt    = PTR'(cnt);
        alloc_ready = (cnt >= ALLOC_WIDTH);
        alloc_n     = ones_below(32'(alloc_req), ALLOC_WIDTH);
        free_n      = ones_below(32'(free_en), FREE_WIDTH);
        walk_n      = ones_below(32'(walk_en), FREE_WIDTH);
        do_alloc    = alloc_fire & alloc_ready & ~redirect & ~walk;
    end

    always_comb begin
        alloc_prd = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++)
            alloc_prd[i*PW +: PW] = ring[idx_add(head[IW-1:0], ones_below(32'(alloc_req), i))];
    end

    // NOTE: the ring itself is reset because its initial contents (the unmapped pregs) are architecturally visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= {1'b1, IW'(0)};
            for (int i = 0; i < FL_DEPTH; i++) ring[i] <= PW'(ARCH_REGS + i);
        end else begin
            // NOTE: non-blocking updates so every write and pointer move uses the pre-edge pointers.
            for (int j = 0; j < FREE_WIDTH; j++)
                if (free_en[j])
                    ring[idx_add(tail[IW-1:0], ones_below(32'(free_en), j))] <= free_prd[j*PW +: PW];
            tail <= ptr_fwd(tail, free_n);
            if (walk)          head <= ptr_back(head, walk_n);
            else if (do_alloc) head <= ptr_fwd(head, alloc_n);
        end
    end

    // Overfilling the ring or rewinding past the allocated region corrupts state.
    assert property (@(posedge clk) disable iff (rst) int'(free_cnt) + free_n <= FL_DEPTH);
    assert property (@(posedge clk) disable iff (rst) !walk || walk_n <= FL_DEPTH - int'(free_cnt));

endmodule
